// File: rtl/regfile_multiport.sv
// -----------------------------------------------------------------------------
// regfile_multiport
//   Parametrised general-purpose register file for the decode stage.
//   One synchronous write port (driven by writeback), NUM_READ combinational
//   read ports, optional write-to-read bypass, optional hard-wired zero
//   register, and a clear sequencer that zeroes one entry per cycle after
//   reset or on request. The storage array has no per-entry reset, so it can
//   map onto distributed RAM.
//
// Ports:
//   clock      in   sole clock, posedge
//   reset      in   synchronous, active-low; restarts the clear sweep
//   ReadReg    in   packed read indices, port k = [k*ADDR_WIDTH +: ADDR_WIDTH]
//   ReadData   out  packed read data,    port k = [k*DATA_WIDTH +: DATA_WIDTH]
//   WriteReg   in   write index
//   WriteData  in   write data
//   RegWrite   in   write enable
//   ClearReq   in   request a full clear sweep (level, sampled only in IDLE)
//   Busy       out  high while the clear sweep runs
//   ClearDone  out  one-cycle pulse on the first IDLE cycle after a sweep
// -----------------------------------------------------------------------------
module regfile_multiport #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] ReadReg,
    output logic [NUM_READ*DATA_WIDTH-1:0] ReadData,
    input  logic [ADDR_WIDTH-1:0]          WriteReg,
    input  logic [DATA_WIDTH-1:0]          WriteData,
    input  logic                           RegWrite,
    input  logic                           ClearReq,
    output logic                           Busy,
    output logic                           ClearDone
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic                    clear_done_q, clear_done_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    mem_we_s;
    logic [ADDR_WIDTH-1:0]   mem_waddr_s;
    logic [DATA_WIDTH-1:0]   mem_wdata_s;
    logic [ADDR_WIDTH-1:0]   rd_idx_s [NUM_READ];

    // Next-state logic: sweep sequencing and arbitration of the single write port
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        clear_done_d = 1'b0;
        mem_we_s     = 1'b0;
        mem_waddr_s  = WriteReg;
        mem_wdata_s  = WriteData;
        case (state_q)
            ST_CLEAR: begin
                // The sweep owns the write port; user writes are dropped.
                mem_we_s    = 1'b1;
                mem_waddr_s = ptr_q;
                mem_wdata_s = '0;
                if (ptr_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d      = ST_IDLE;
                    clear_done_d = 1'b1;
                end else begin
                    ptr_d = ptr_q + ADDR_WIDTH'(1);
                end
            end
            ST_IDLE: begin
                if (ClearReq) begin
                    // Clear wins over a same-cycle write.
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end else if (RegWrite && !((ZERO_REG != 0) && (WriteReg == '0))) begin
                    mem_we_s = 1'b1;
                end else begin
                    mem_we_s = 1'b0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    // Control registers with synchronous active-low reset that restarts the sweep
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= ST_CLEAR;
            ptr_q        <= '0;
            clear_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            clear_done_q <= clear_done_d;
        end
    end

    // Storage write; no reset on the array, reset only blocks the write
    always_ff @(posedge clock) begin
        if (reset && mem_we_s) begin
            mem_q[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Unpack the per-port read indices
    for (genvar k = 0; k < NUM_READ; k++) begin : g_idx
        assign rd_idx_s[k] = ReadReg[k*ADDR_WIDTH +: ADDR_WIDTH];
    end

    // Combinational read ports in priority order: busy, zero reg, bypass, array
    always_comb begin
        ReadData = '0;
        for (int k = 0; k < NUM_READ; k++) begin
            if (state_q == ST_CLEAR) begin
                ReadData[k*DATA_WIDTH +: DATA_WIDTH] = '0;
            end else if ((ZERO_REG != 0) && (rd_idx_s[k] == '0)) begin
                ReadData[k*DATA_WIDTH +: DATA_WIDTH] = '0;
            end else if ((BYPASS != 0) && RegWrite && !ClearReq && (WriteReg == rd_idx_s[k])) begin
                ReadData[k*DATA_WIDTH +: DATA_WIDTH] = WriteData;
            end else begin
                ReadData[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_idx_s[k]];
            end
        end
    end

    assign Busy      = (state_q == ST_CLEAR);
    assign ClearDone = clear_done_q;

endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport: two default-sized instances sharing stimulus
// (BYPASS=1 and BYPASS=0) plus a small 8x8, 4-read, no-zero-register instance.
// Expectations are queued when stimulus is driven and compared 1 time unit
// after each falling edge.
module tb_regfile_multiport;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // Shared stimulus for instances A (bypass) and B (no bypass)
    logic        reset, ClearReq, RegWrite;
    logic [9:0]  ReadReg;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic [63:0] rd_a, rd_b;
    logic        busy_a, busy_b, done_a, done_b;

    // Stimulus for the small instance C
    logic        c_reset, c_clr, c_we;
    logic [11:0] c_rreg;
    logic [2:0]  c_wreg;
    logic [7:0]  c_wdata;
    logic [31:0] c_rd;
    logic        c_busy, c_done;

    regfile_multiport #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clock(clock), .reset(reset), .ReadReg(ReadReg), .ReadData(rd_a),
        .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite),
        .ClearReq(ClearReq), .Busy(busy_a), .ClearDone(done_a));

    regfile_multiport #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2), .ZERO_REG(1), .BYPASS(0)) dut_b (
        .clock(clock), .reset(reset), .ReadReg(ReadReg), .ReadData(rd_b),
        .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite),
        .ClearReq(ClearReq), .Busy(busy_b), .ClearDone(done_b));

    regfile_multiport #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .NUM_READ(4), .ZERO_REG(0), .BYPASS(1)) dut_c (
        .clock(clock), .reset(c_reset), .ReadReg(c_rreg), .ReadData(c_rd),
        .WriteReg(c_wreg), .WriteData(c_wdata), .RegWrite(c_we),
        .ClearReq(c_clr), .Busy(c_busy), .ClearDone(c_done));

    typedef struct {
        int          id;
        bit          chk_rd;
        logic [31:0] a0, a1, b0, b1;
        logic        busy, done;
        bit          chk_c;
        logic [31:0] c_rd;
        logic        c_busy, c_done;
    } exp_t;

    typedef struct {
        logic        we;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic [4:0]  r0, r1;
        logic [31:0] a0, a1, b0, b1;
    } vec_t;

    exp_t sb_q[$];
    exp_t cur;
    vec_t vecs[9];
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t mk(input int id, input logic [31:0] a0, input logic [31:0] a1,
                                input logic [31:0] b0, input logic [31:0] b1,
                                input logic busy, input logic done);
        exp_t e;
        e.id = id; e.chk_rd = 1'b1;
        e.a0 = a0; e.a1 = a1; e.b0 = b0; e.b1 = b1;
        e.busy = busy; e.done = done;
        e.chk_c = 1'b0; e.c_rd = 32'h0; e.c_busy = 1'b0; e.c_done = 1'b0;
        return e;
    endfunction

    function automatic exp_t mkc(input int id, input logic [31:0] rd,
                                 input logic busy, input logic done);
        exp_t e;
        e = mk(id, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        e.chk_rd = 1'b0;
        e.chk_c = 1'b1; e.c_rd = rd; e.c_busy = busy; e.c_done = done;
        return e;
    endfunction

    task automatic cmp(input string nm, input int id, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", nm, id, got, exp);
        end
    endtask

    // Scoreboard consumer: compare everything queued at this falling edge
    always @(negedge clock) begin
        #1;
        while (sb_q.size() > 0) begin
            cur = sb_q.pop_front();
            cmp("busy_a", cur.id, {31'b0, busy_a}, {31'b0, cur.busy});
            cmp("busy_b", cur.id, {31'b0, busy_b}, {31'b0, cur.busy});
            cmp("done_a", cur.id, {31'b0, done_a}, {31'b0, cur.done});
            cmp("done_b", cur.id, {31'b0, done_b}, {31'b0, cur.done});
            if (cur.chk_rd) begin
                cmp("rd_a0", cur.id, rd_a[31:0],  cur.a0);
                cmp("rd_a1", cur.id, rd_a[63:32], cur.a1);
                cmp("rd_b0", cur.id, rd_b[31:0],  cur.b0);
                cmp("rd_b1", cur.id, rd_b[63:32], cur.b1);
            end
            if (cur.chk_c) begin
                cmp("rd_c",   cur.id, c_rd, cur.c_rd);
                cmp("busy_c", cur.id, {31'b0, c_busy}, {31'b0, cur.c_busy});
                cmp("done_c", cur.id, {31'b0, c_done}, {31'b0, cur.c_done});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        //             we    wr     wd            r0     r1     a0            a1            b0            b1
        vecs[0] = '{1'b1, 5'd7,  32'hDEADBEEF, 5'd7,  5'd31, 32'hDEADBEEF, 32'h00000000, 32'h00000000, 32'h00000000};
        vecs[1] = '{1'b1, 5'd31, 32'h12345678, 5'd7,  5'd31, 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 32'h00000000};
        vecs[2] = '{1'b0, 5'd0,  32'h00000000, 5'd7,  5'd31, 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 32'h12345678};
        vecs[3] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};
        vecs[4] = '{1'b0, 5'd0,  32'h00000000, 5'd0,  5'd0,  32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};
        vecs[5] = '{1'b1, 5'd5,  32'hA5A5A5A5, 5'd5,  5'd5,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'h00000000, 32'h00000000};
        vecs[6] = '{1'b0, 5'd0,  32'h00000000, 5'd5,  5'd5,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5};
        vecs[7] = '{1'b1, 5'd5,  32'h11111111, 5'd5,  5'd7,  32'h11111111, 32'hDEADBEEF, 32'hA5A5A5A5, 32'hDEADBEEF};
        vecs[8] = '{1'b0, 5'd0,  32'h00000000, 5'd5,  5'd31, 32'h11111111, 32'h12345678, 32'h11111111, 32'h12345678};

        reset = 1'b0; ClearReq = 1'b0; RegWrite = 1'b0; ReadReg = 10'd0;
        WriteReg = 5'd0; WriteData = 32'h0;
        c_reset = 1'b0; c_clr = 1'b0; c_we = 1'b0; c_rreg = 12'd0;
        c_wreg = 3'd0; c_wdata = 8'h0;
        repeat (3) @(posedge clock);

        // Reset release: A/B busy 32 cycles, C busy 8 cycles; reads are 0
        for (int cyc = 1; cyc <= 34; cyc++) begin
            @(negedge clock);
            reset = 1'b1; c_reset = 1'b1;
            ReadReg = {5'(cyc + 3), 5'(cyc)};
            c_rreg = {3'(cyc), 3'(cyc + 1), 3'(cyc + 2), 3'(cyc + 3)};
            e = mk(cyc, 32'h0, 32'h0, 32'h0, 32'h0, (cyc <= 32), (cyc == 33));
            e.chk_c = 1'b1; e.c_rd = 32'h0; e.c_busy = (cyc <= 8); e.c_done = (cyc == 9);
            sb_q.push_back(e);
        end
        // Every entry reads back zero after the sweep
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            ReadReg = {5'(2 * i + 1), 5'(2 * i)};
            c_rreg = (i == 0) ? {3'd3, 3'd2, 3'd1, 3'd0} : {3'd7, 3'd6, 3'd5, 3'd4};
            e = mk(50 + i, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
            if (i < 2) begin
                e.chk_c = 1'b1; e.c_rd = 32'h0; e.c_busy = 1'b0; e.c_done = 1'b0;
            end
            sb_q.push_back(e);
        end

        // Table-driven write/read/bypass vectors
        for (int i = 0; i < 9; i++) begin
            @(negedge clock);
            RegWrite = vecs[i].we; WriteReg = vecs[i].wr; WriteData = vecs[i].wd;
            ReadReg = {vecs[i].r1, vecs[i].r0};
            sb_q.push_back(mk(100 + i, vecs[i].a0, vecs[i].a1, vecs[i].b0, vecs[i].b1, 1'b0, 1'b0));
        end

        // Clear request with a same-cycle write: write dropped, no bypass
        @(negedge clock);
        ClearReq = 1'b1; RegWrite = 1'b1; WriteReg = 5'd3; WriteData = 32'h55;
        ReadReg = {5'd7, 5'd3};
        sb_q.push_back(mk(200, 32'h0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0));
        for (int k = 1; k <= 34; k++) begin
            @(negedge clock);
            ClearReq = (k == 5);
            RegWrite = (k <= 32); WriteReg = 5'd3; WriteData = 32'h77;
            ReadReg = (k == 34) ? {5'd7, 5'd3} : {5'd3, 5'd3};
            sb_q.push_back(mk(200 + k, 32'h0, 32'h0, 32'h0, 32'h0, (k <= 32), (k == 33)));
        end

        // Reset mid-sweep restarts the sweep; writes during the sweep are lost
        @(negedge clock);
        ClearReq = 1'b0; RegWrite = 1'b1; WriteReg = 5'd9; WriteData = 32'hCAFEF00D;
        ReadReg = {5'd9, 5'd9};
        sb_q.push_back(mk(300, 32'hCAFEF00D, 32'hCAFEF00D, 32'h0, 32'h0, 1'b0, 1'b0));
        @(negedge clock);
        ClearReq = 1'b1; RegWrite = 1'b0;
        sb_q.push_back(mk(301, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 1'b0));
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            ClearReq = 1'b0; RegWrite = 1'b1; WriteData = 32'hBAD0BAD0;
            reset = (k == 10) ? 1'b0 : 1'b1;
            sb_q.push_back(mk(310 + k, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0));
        end
        for (int j = 1; j <= 34; j++) begin
            @(negedge clock);
            reset = 1'b1; RegWrite = (j <= 32);
            sb_q.push_back(mk(330 + j, 32'h0, 32'h0, 32'h0, 32'h0, (j <= 32), (j == 33)));
        end

        // Small instance: index 0 is an ordinary register, four read ports
        @(negedge clock);
        RegWrite = 1'b0;
        c_we = 1'b1; c_wreg = 3'd0; c_wdata = 8'h3C; c_rreg = {3'd0, 3'd0, 3'd0, 3'd0};
        sb_q.push_back(mkc(400, 32'h3C3C3C3C, 1'b0, 1'b0));
        @(negedge clock);
        c_rreg = {3'd0, 3'd0, 3'd0, 3'd0}; c_we = 1'b0;
        sb_q.push_back(mkc(401, 32'h3C3C3C3C, 1'b0, 1'b0));
        @(negedge clock);
        c_we = 1'b1; c_wreg = 3'd7; c_wdata = 8'h81; c_rreg = {3'd0, 3'd7, 3'd0, 3'd7};
        sb_q.push_back(mkc(402, 32'h3C813C81, 1'b0, 1'b0));
        @(negedge clock);
        c_we = 1'b0; c_rreg = {3'd7, 3'd7, 3'd0, 3'd0};
        sb_q.push_back(mkc(403, 32'h81813C3C, 1'b0, 1'b0));
        @(negedge clock);
        c_clr = 1'b1; c_we = 1'b1; c_wreg = 3'd0; c_wdata = 8'hFF; c_rreg = {3'd0, 3'd0, 3'd0, 3'd0};
        sb_q.push_back(mkc(404, 32'h3C3C3C3C, 1'b0, 1'b0));
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            c_clr = 1'b0; c_we = 1'b0; c_rreg = {3'd0, 3'd7, 3'd0, 3'd7};
            sb_q.push_back(mkc(410 + k, 32'h0, (k <= 8), (k == 9)));
        end

        @(negedge clock);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
